// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the PCI bus arbiter.
package pci_arb_pkg;

   // Arbiter sequencing states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      BUSY  = 2'd2,
      TURN  = 2'd3
   } arb_state_t;

   localparam int DEF_NUM_MASTERS = 3;
   localparam int DEF_GNT_TIMEOUT = 16;

   // Owner index width; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pci_rr_pick.sv
// Combinational rotating-priority picker: first asserted request after rr_ptr wins.
module pci_rr_pick
   import pci_arb_pkg::*;
#(
   parameter int NUM_MASTERS = DEF_NUM_MASTERS,
   parameter int IDX_W       = idx_width(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [IDX_W-1:0]       rr_ptr,
   output logic [IDX_W-1:0]       winner,
   output logic                   valid
);

   // Scan from the farthest candidate back to the nearest so the nearest asserted one is kept.
   always_comb begin
      int idx;
      winner = '0;
      valid  = 1'b0;
      idx    = 0;
      for (int k = NUM_MASTERS; k >= 1; k--) begin
         idx = (int'(rr_ptr) + k) % NUM_MASTERS;
         if (req[idx[IDX_W-1:0]]) begin
            winner = idx[IDX_W-1:0];
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI arbiter: round-robin grants, turnaround insertion, unused-grant timeout.
//
// state | meaning
// IDLE  | no grant driven; grant the round-robin winner once the bus is idle
// GRANT | grant driven, waiting for the owner to assert FRAME
// BUSY  | owner's transaction in progress; grant may be withdrawn early
// TURN  | one cycle with every grant high before the next arbitration
module pci_bus_arbiter
   import pci_arb_pkg::*;
#(
   parameter int NUM_MASTERS = DEF_NUM_MASTERS,
   parameter int GNT_TIMEOUT = DEF_GNT_TIMEOUT,
   parameter int IDX_W       = idx_width(NUM_MASTERS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_MASTERS-1:0] req_n,
   input  logic                   frame_n,
   input  logic                   irdy_n,
   output logic [NUM_MASTERS-1:0] gnt_n,
   output logic [IDX_W-1:0]       owner,
   output logic                   bus_busy,
   output logic                   timeout_err
);

   localparam int TW = $clog2(GNT_TIMEOUT) + 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(GNT_TIMEOUT - 1);

   arb_state_t             state;
   logic [IDX_W-1:0]       rr_ptr;
   logic [TW-1:0]          timer;

   logic [NUM_MASTERS-1:0] req_act;
   logic [NUM_MASTERS-1:0] owner_mask;
   logic [NUM_MASTERS-1:0] pick_gnt;
   logic                   frame_act;
   logic                   irdy_act;
   logic                   bus_idle;
   logic                   owner_req;
   logic                   other_req;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_valid;

   // Only a clean 0 counts as asserted; floating or unknown lines read as released.
   always_comb begin
      req_act = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         req_act[i] = (req_n[i] === 1'b0);
      end
      frame_act  = (frame_n === 1'b0);
      irdy_act   = (irdy_n === 1'b0);
      bus_idle   = !frame_act && !irdy_act;
      owner_mask = '0;
      owner_mask[owner] = 1'b1;
      owner_req  = |(req_act & owner_mask);
      other_req  = |(req_act & ~owner_mask);
      pick_gnt   = '1;
      pick_gnt[pick_idx] = 1'b0;
   end

   pci_rr_pick #(
      .NUM_MASTERS (NUM_MASTERS),
      .IDX_W       (IDX_W)
   ) u_pick (
      .req    (req_act),
      .rr_ptr (rr_ptr),
      .winner (pick_idx),
      .valid  (pick_valid)
   );

   // Arbitration sequencing with registered grant, owner and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         gnt_n       <= '1;
         owner       <= '0;
         rr_ptr      <= IDX_W'(NUM_MASTERS - 1);
         timer       <= '0;
         bus_busy    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         bus_busy    <= frame_act || irdy_act;
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               gnt_n <= '1;
               if (pick_valid && bus_idle) begin
                  state  <= GRANT;
                  gnt_n  <= pick_gnt;
                  owner  <= pick_idx;
                  rr_ptr <= pick_idx;
                  timer  <= '0;
               end
            end
            GRANT: begin
               // FRAME takes precedence over withdrawal and timeout on the same edge.
               if (frame_act) begin
                  state <= BUSY;
                  timer <= '0;
               end else if (!owner_req) begin
                  state <= TURN;
                  gnt_n <= '1;
               end else if (timer == TIMER_LAST) begin
                  state       <= TURN;
                  gnt_n       <= '1;
                  timeout_err <= 1'b1;
               end else if (timer != '1) begin
                  timer <= timer + TW'(1);
               end
            end
            BUSY: begin
               // Grant can only be withdrawn here; it is never re-driven before TURN.
               if (bus_idle) begin
                  state <= TURN;
                  gnt_n <= '1;
               end else if (!owner_req || other_req) begin
                  gnt_n <= '1;
               end
            end
            TURN: begin
               state <= IDLE;
               gnt_n <= '1;
            end
            default: begin
               state <= IDLE;
               gnt_n <= '1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Self-checking bench for pci_bus_arbiter with a transaction-level reference model.
module tb_pci_bus_arbiter;

   localparam int NM  = 3;
   localparam int TMO = 16;
   localparam int IW  = 2;

   logic          clk;
   logic          reset;
   logic [NM-1:0] req_n;
   logic          frame_n;
   logic          irdy_n;
   logic [NM-1:0] gnt_n;
   logic [IW-1:0] owner;
   logic          bus_busy;
   logic          timeout_err;

   int errors = 0;
   int checks = 0;

   // reference model: who holds the bus, whether a transaction has started,
   // how long the grant has gone unused and how many cool-down edges remain
   int m_owner;
   int m_last;
   int m_age;
   int m_cool;
   bit m_own;
   bit m_txn;
   bit m_hold;
   bit m_busy;
   bit m_terr;

   pci_bus_arbiter #(
      .NUM_MASTERS (NM),
      .GNT_TIMEOUT (TMO),
      .IDX_W       (IW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_n       (req_n),
      .frame_n     (frame_n),
      .irdy_n      (irdy_n),
      .gnt_n       (gnt_n),
      .owner       (owner),
      .bus_busy    (bus_busy),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   function automatic bit asrt(input logic v);
      return (v === 1'b0);
   endfunction

   task automatic release_bus();
      m_own  = 1'b0;
      m_txn  = 1'b0;
      m_hold = 1'b0;
      m_cool = 1;
   endtask

   task automatic model_step();
      bit f;
      bit i;
      bit idle;
      bit others;
      f    = asrt(frame_n);
      i    = asrt(irdy_n);
      idle = !f && !i;
      m_terr = 1'b0;
      if (reset === 1'b1) begin
         m_owner = 0;
         m_last  = NM - 1;
         m_own   = 1'b0;
         m_txn   = 1'b0;
         m_hold  = 1'b0;
         m_cool  = 0;
         m_age   = 0;
         m_busy  = 1'b0;
         return;
      end
      m_busy = f || i;
      if (m_cool > 0) begin
         m_cool--;
      end else if (!m_own) begin
         if (idle) begin
            for (int k = 1; k <= NM; k++) begin
               int c;
               c = (m_last + k) % NM;
               if (asrt(req_n[c[IW-1:0]])) begin
                  m_owner = c;
                  m_last  = c;
                  m_own   = 1'b1;
                  m_hold  = 1'b1;
                  m_age   = 0;
                  break;
               end
            end
         end
      end else if (!m_txn) begin
         if (f) begin
            m_txn = 1'b1;
         end else if (!asrt(req_n[m_owner[IW-1:0]])) begin
            release_bus();
         end else if (m_age == TMO - 1) begin
            release_bus();
            m_terr = 1'b1;
         end else begin
            m_age++;
         end
      end else begin
         others = 1'b0;
         for (int k = 0; k < NM; k++) begin
            if (k != m_owner && asrt(req_n[k])) others = 1'b1;
         end
         if (idle) release_bus();
         else if (!asrt(req_n[m_owner[IW-1:0]]) || others) m_hold = 1'b0;
      end
   endtask

   function automatic logic [NM+IW+1:0] exp_vec();
      logic [NM-1:0] g;
      g = '1;
      if (m_hold) g[m_owner[IW-1:0]] = 1'b0;
      return {g, m_owner[IW-1:0], m_busy, m_terr};
   endfunction

   task automatic step(input logic [NM-1:0] r, input logic f, input logic i, input logic rs);
      @(negedge clk);
      req_n   = r;
      frame_n = f;
      irdy_n  = i;
      reset   = rs;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      step(3'b111, 1'b1, 1'b1, 1'b1);
      step(3'b111, 1'b1, 1'b1, 1'b1);
      checks++;
      if ({gnt_n, owner, bus_busy, timeout_err} !== {3'b111, 2'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_values: got gnt=%b owner=%0d busy=%b terr=%b, want 111/0/0/0",
                  gnt_n, owner, bus_busy, timeout_err);
      end
      for (int n = 0; n < 10; n++) begin
         step(3'b111, 1'b1, 1'b1, 1'b0);
         checks++;
         if (gnt_n !== 3'b111 || owner !== 2'd0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req cycle %0d: got gnt=%b owner=%0d terr=%b, want 111/0/0",
                     n, gnt_n, owner, timeout_err);
         end
      end
   endtask

   task automatic test_single();
      logic [NM-1:0] fr[4];
      logic          ir[4];
      fr = '{1'b0, 1'b0, 1'b0, 1'b1};
      ir = '{1'b1, 1'b0, 1'b0, 1'b0};
      step(3'b111, 1'b1, 1'b1, 1'b1);
      step(3'b110, 1'b1, 1'b1, 1'b0);
      checks++;
      if (gnt_n !== 3'b110 || owner !== 2'd0) begin
         errors++;
         $display("FAIL single_grant: got gnt=%b owner=%0d, want 110/0", gnt_n, owner);
      end
      for (int p = 0; p < 4; p++) begin
         step(3'b110, fr[p][0], ir[p], 1'b0);
         checks++;
         if (gnt_n !== 3'b110 || bus_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy phase %0d: got gnt=%b busy=%b, want 110/1", p, gnt_n, bus_busy);
         end
      end
      step(3'b110, 1'b1, 1'b1, 1'b0);
      checks++;
      if (gnt_n !== 3'b111 || bus_busy !== 1'b0) begin
         errors++;
         $display("FAIL single_turn: got gnt=%b busy=%b, want 111/0", gnt_n, bus_busy);
      end
      step(3'b111, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({gnt_n, owner, bus_busy, timeout_err} !== exp_vec()) begin
         errors++;
         $display("FAIL single_after: got %b want %b", {gnt_n, owner, bus_busy, timeout_err}, exp_vec());
      end
   endtask

   task automatic test_round_robin();
      int exp_order[4];
      bit got;
      exp_order = '{0, 1, 2, 0};
      step(3'b111, 1'b1, 1'b1, 1'b1);
      for (int t = 0; t < 4; t++) begin
         got = 1'b0;
         for (int w = 0; w < 8 && !got; w++) begin
            step(3'b000, 1'b1, 1'b1, 1'b0);
            checks++;
            if ({gnt_n, owner, bus_busy, timeout_err} !== exp_vec()) begin
               errors++;
               $display("FAIL rr_model: got %b want %b", {gnt_n, owner, bus_busy, timeout_err}, exp_vec());
            end
            if (gnt_n !== 3'b111) got = 1'b1;
         end
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL rr_wait grant %0d: got no grant in 8 cycles, want a grant", t);
         end else if (int'(owner) != exp_order[t] || $countones(~gnt_n) != 1) begin
            errors++;
            $display("FAIL rr_order grant %0d: got owner=%0d gnt=%b, want owner=%0d one-hot",
                     t, owner, gnt_n, exp_order[t]);
         end
         step(3'b000, 1'b0, 1'b1, 1'b0);
         step(3'b000, 1'b0, 1'b0, 1'b0);
         checks++;
         if ($countones(~gnt_n) > 1 || {gnt_n, owner, bus_busy, timeout_err} !== exp_vec()) begin
            errors++;
            $display("FAIL rr_busy %0d: got %b want %b", t, {gnt_n, owner, bus_busy, timeout_err}, exp_vec());
         end
      end
   endtask

   task automatic test_timeout();
      step(3'b111, 1'b1, 1'b1, 1'b1);
      step(3'b001, 1'b1, 1'b1, 1'b0);
      checks++;
      if (gnt_n !== 3'b101 || owner !== 2'd1) begin
         errors++;
         $display("FAIL tmo_grant: got gnt=%b owner=%0d, want 101/1", gnt_n, owner);
      end
      for (int n = 1; n < TMO; n++) begin
         step(3'b001, 1'b1, 1'b1, 1'b0);
         checks++;
         if (gnt_n !== 3'b101 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_hold cycle %0d: got gnt=%b terr=%b, want 101/0", n, gnt_n, timeout_err);
         end
      end
      step(3'b001, 1'b1, 1'b1, 1'b0);
      checks++;
      if (gnt_n !== 3'b111 || timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL tmo_revoke: got gnt=%b terr=%b, want 111/1", gnt_n, timeout_err);
      end
      step(3'b001, 1'b1, 1'b1, 1'b0);
      checks++;
      if (gnt_n !== 3'b111 || timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL tmo_pulse_once: got gnt=%b terr=%b, want 111/0", gnt_n, timeout_err);
      end
      step(3'b001, 1'b1, 1'b1, 1'b0);
      checks++;
      if (gnt_n !== 3'b011 || owner !== 2'd2) begin
         errors++;
         $display("FAIL tmo_next: got gnt=%b owner=%0d, want 011/2", gnt_n, owner);
      end
   endtask

   task automatic test_hidden();
      logic [NM-1:0] exp_g[6];
      exp_g = '{3'b110, 3'b111, 3'b111, 3'b111, 3'b111, 3'b011};
      step(3'b111, 1'b1, 1'b1, 1'b1);
      step(3'b110, 1'b1, 1'b1, 1'b0);
      step(3'b110, 1'b0, 1'b1, 1'b0);
      checks++;
      if (gnt_n !== exp_g[0]) begin
         errors++;
         $display("FAIL hidden_busy: got gnt=%b, want %b", gnt_n, exp_g[0]);
      end
      step(3'b010, 1'b0, 1'b0, 1'b0);
      checks++;
      if (gnt_n !== exp_g[1]) begin
         errors++;
         $display("FAIL hidden_drop: got gnt=%b, want %b", gnt_n, exp_g[1]);
      end
      for (int n = 2; n < 6; n++) begin
         step(3'b010, (n == 2) ? 1'b0 : 1'b1, (n == 2) ? 1'b0 : 1'b1, 1'b0);
         checks++;
         if (gnt_n !== exp_g[n]) begin
            errors++;
            $display("FAIL hidden_seq %0d: got gnt=%b, want %b", n, gnt_n, exp_g[n]);
         end
      end
      checks++;
      if (owner !== 2'd2) begin
         errors++;
         $display("FAIL hidden_owner: got owner=%0d, want 2", owner);
      end
   endtask

   task automatic test_reset_busy();
      step(3'b111, 1'b1, 1'b1, 1'b1);
      step(3'b110, 1'b1, 1'b1, 1'b0);
      step(3'b110, 1'b0, 1'b1, 1'b0);
      step(3'b110, 1'b0, 1'b0, 1'b0);
      step(3'b110, 1'b0, 1'b0, 1'b1);
      checks++;
      if (gnt_n !== 3'b111 || bus_busy !== 1'b0) begin
         errors++;
         $display("FAIL rstbusy_drop: got gnt=%b busy=%b, want 111/0", gnt_n, bus_busy);
      end
      step(3'b110, 1'b0, 1'b0, 1'b1);
      step(3'b000, 1'b1, 1'b1, 1'b0);
      checks++;
      if (gnt_n !== 3'b110 || owner !== 2'd0) begin
         errors++;
         $display("FAIL rstbusy_restart: got gnt=%b owner=%0d, want 110/0", gnt_n, owner);
      end
   endtask

   task automatic test_random();
      int lowp;
      logic [NM-1:0] r;
      logic f;
      logic i;
      logic rs;
      step(3'b111, 1'b1, 1'b1, 1'b1);
      for (int b = 0; b < 24; b++) begin
         case ($urandom_range(0, 3))
            0: lowp = 0;
            1: lowp = 10;
            2: lowp = 40;
            default: lowp = 80;
         endcase
         for (int c = 0; c < 100; c++) begin
            r  = NM'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) r = r | req_n;
            f  = ($urandom_range(0, 99) < lowp) ? 1'b0 : 1'b1;
            i  = ($urandom_range(0, 99) < lowp) ? 1'b0 : 1'b1;
            rs = ($urandom_range(0, 499) == 0);
            step(r, f, i, rs);
            checks++;
            if ($countones(~gnt_n) > 1 || {gnt_n, owner, bus_busy, timeout_err} !== exp_vec()) begin
               errors++;
               $display("FAIL random b%0d c%0d: got gnt/own/busy/terr=%b want %b",
                        b, c, {gnt_n, owner, bus_busy, timeout_err}, exp_vec());
            end
         end
      end
   endtask

   initial begin
      reset   = 1'b1;
      req_n   = '1;
      frame_n = 1'b1;
      irdy_n  = 1'b1;
      m_owner = 0;
      m_last  = NM - 1;
      m_age   = 0;
      m_cool  = 0;
      m_own   = 1'b0;
      m_txn   = 1'b0;
      m_hold  = 1'b0;
      m_busy  = 1'b0;
      m_terr  = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_hidden();
      test_reset_busy();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
